// File: rtl/frame_deframer.sv
// rtl/frame_deframer.sv - FAS search, frame position tracking and overhead strip to payload.
// Optional macro FAS_ERR_CNT_EN adds the saturating o_fas_err_cnt output.
module frame_deframer #(
    parameter int NUM_COLS   = 1041,
    parameter int NUM_ROWS   = 4,
    parameter int OH_COLS    = 16,
    parameter int OOF_THRESH = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_frame_data,
    input  logic        i_frame_data_valid,
    output logic [7:0]  o_pyld_data,
    output logic        o_pyld_data_valid,
    output logic        o_pyld_sof,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic        o_in_frame,
    output logic        o_fas_err
`ifdef FAS_ERR_CNT_EN
    ,
    output logic [15:0] o_fas_err_cnt
`endif
);

    localparam logic [47:0] FAS_PATTERN = 48'hF6F6F6282828;
    localparam logic [10:0] LAST_COL    = 11'(NUM_COLS - 1);
    localparam logic [1:0]  LAST_ROW    = 2'(NUM_ROWS - 1);
    localparam logic [10:0] PYLD_COL0   = 11'(OH_COLS);
    localparam logic [10:0] FAS_END_COL = 11'd5;
    localparam logic [10:0] POST_FAS    = 11'd6;
    localparam logic [7:0]  MISS_LIMIT  = 8'(OOF_THRESH);

    typedef enum logic [1:0] {
        ST_OOF,
        ST_PRESYNC,
        ST_IN_FRAME
    } state_t;

    state_t      state;
    // The five previous bytes; together with the current byte they form the 48-bit search window.
    logic [39:0] hist;
    logic [1:0]  row;
    logic [10:0] col;
    logic [7:0]  miss_cnt;

    logic [47:0] window;
    logic        fas_hit;
    logic        at_check;
    logic        is_payload;
    logic [1:0]  row_inc;
    logic [10:0] col_inc;

    always_comb begin
        window     = {hist, i_frame_data};
        fas_hit    = (window == FAS_PATTERN);
        at_check   = (row == 2'd0) && (col == FAS_END_COL);
        is_payload = (col >= PYLD_COL0) && (col != LAST_COL);
        col_inc    = col + 11'd1;
        row_inc    = row;
        if (col == LAST_COL) begin
            col_inc = 11'd0;
            row_inc = (row == LAST_ROW) ? 2'd0 : row + 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= ST_OOF;
            hist              <= '0;
            row               <= '0;
            col               <= '0;
            miss_cnt          <= '0;
            o_pyld_data       <= '0;
            o_pyld_data_valid <= 1'b0;
            o_pyld_sof        <= 1'b0;
            o_row_cnt         <= '0;
            o_col_cnt         <= '0;
            o_in_frame        <= 1'b0;
            o_fas_err         <= 1'b0;
        end else begin
            o_pyld_data_valid <= 1'b0;
            o_pyld_sof        <= 1'b0;
            o_fas_err         <= 1'b0;
            if (i_frame_data_valid) begin
                hist      <= window[39:0];
                row       <= row_inc;
                col       <= col_inc;
                o_row_cnt <= row;
                o_col_cnt <= col;
                case (state)
                    ST_OOF: begin
                        if (fas_hit) begin
                            row   <= 2'd0;
                            col   <= POST_FAS;
                            state <= ST_PRESYNC;
                        end
                    end
                    ST_PRESYNC: begin
                        if (at_check) begin
                            if (fas_hit) begin
                                state      <= ST_IN_FRAME;
                                miss_cnt   <= '0;
                                o_in_frame <= 1'b1;
                            end else begin
                                state     <= ST_OOF;
                                o_fas_err <= 1'b1;
                            end
                        end
                    end
                    ST_IN_FRAME: begin
                        if (is_payload) begin
                            o_pyld_data       <= i_frame_data;
                            o_pyld_data_valid <= 1'b1;
                            o_pyld_sof        <= (row == 2'd0) && (col == PYLD_COL0);
                        end
                        if (at_check) begin
                            if (fas_hit) begin
                                miss_cnt <= '0;
                            end else begin
                                o_fas_err <= 1'b1;
                                if (miss_cnt + 8'd1 >= MISS_LIMIT) begin
                                    state      <= ST_OOF;
                                    miss_cnt   <= '0;
                                    o_in_frame <= 1'b0;
                                end else begin
                                    miss_cnt <= miss_cnt + 8'd1;
                                end
                            end
                        end
                    end
                    default: state <= ST_OOF;
                endcase
            end
        end
    end

`ifdef FAS_ERR_CNT_EN
    // Counts registered pulses, so the count trails o_fas_err by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fas_err_cnt <= '0;
        end else if (o_fas_err && (o_fas_err_cnt != 16'hFFFF)) begin
            o_fas_err_cnt <= o_fas_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_deframer.sv
// tb/tb_frame_deframer.sv - directed self-checking bench for frame_deframer.
module tb_frame_deframer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [7:0]  pyld_data;
    logic        pyld_valid;
    logic        pyld_sof;
    logic [1:0]  row_cnt;
    logic [10:0] col_cnt;
    logic        in_frame;
    logic        fas_err;
`ifdef FAS_ERR_CNT_EN
    logic [15:0] fas_err_cnt;
`endif

    frame_deframer dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_frame_data       (in_data),
        .i_frame_data_valid (in_valid),
        .o_pyld_data        (pyld_data),
        .o_pyld_data_valid  (pyld_valid),
        .o_pyld_sof         (pyld_sof),
        .o_row_cnt          (row_cnt),
        .o_col_cnt          (col_cnt),
        .o_in_frame         (in_frame),
        .o_fas_err          (fas_err)
`ifdef FAS_ERR_CNT_EN
        ,
        .o_fas_err_cnt      (fas_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         f_pyld, f_err, f_fas, f_sof, tot_fas;
    logic [7:0] f_first, last_pd;
    logic       f_first_sof, f_first_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int r, input int c, input bit corrupt, input bit inject);
        if (r == 0 && c < 6) begin
            if (corrupt && c == 3) return 8'h00;
            return (c < 3) ? 8'hF6 : 8'h28;
        end
        if (inject && r == 1 && c >= 100 && c < 106) return (c < 103) ? 8'hF6 : 8'h28;
        if (c < 16) return 8'h00;
        if (c == 1040) return 8'hAA;
        return 8'(c) ^ 8'(r);
    endfunction

    // Called #1 after each clock edge; exp_v says whether this cycle must carry payload byte d.
    task automatic observe(input bit exp_v, input logic [7:0] d, input int r, input int c, input bit chk_pos);
        if (fas_err) begin
            f_fas++;
            tot_fas++;
        end
        if (pyld_valid) begin
            f_pyld++;
            if (pyld_sof) f_sof++;
            if (!f_first_seen) begin
                f_first_seen = 1'b1;
                f_first      = pyld_data;
                f_first_sof  = pyld_sof;
            end
        end
        if (pyld_valid !== exp_v) f_err++;
        if (exp_v) begin
            if (pyld_data !== d || pyld_sof !== (r == 0 && c == 16)) f_err++;
            last_pd = d;
        end else if (pyld_data !== last_pd || pyld_sof !== 1'b0) begin
            f_err++;
        end
        if (chk_pos && (row_cnt !== 2'(r) || col_cnt !== 11'(c))) f_err++;
    endtask

    task automatic send_frame(input bit locked, input bit corrupt, input bit gaps, input bit inject, input int nbytes);
        logic [7:0] d;
        int         n;
        f_pyld = 0; f_err = 0; f_fas = 0; f_sof = 0;
        f_first = 8'h00; f_first_sof = 1'b0; f_first_seen = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 1041; c++) begin
                if (r * 1041 + c >= nbytes) return;
                d        = fbyte(r, c, corrupt, inject);
                in_data  = d;
                in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                observe(locked && c >= 16 && c != 1040, d, r, c, locked);
                if (gaps) begin
                    n = $urandom_range(0, 3);
                    repeat (n) begin
                        @(posedge clk); #1;
                        observe(1'b0, 8'h00, 0, 0, 1'b0);
                    end
                end
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pyld_valid"}, pyld_valid, 0);
        check({tag, "_pyld_data"}, pyld_data, 0);
        check({tag, "_sof"}, pyld_sof, 0);
        check({tag, "_row"}, row_cnt, 0);
        check({tag, "_col"}, col_cnt, 0);
        check({tag, "_in_frame"}, in_frame, 0);
        check({tag, "_fas_err"}, fas_err, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        last_pd = 8'h00;
        tot_fas = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        last_pd  = 8'h00;
        tot_fas  = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // First FAS only reaches PRESYNC; the second one locks.
        send_frame(0, 0, 0, 0, 4164);
        check("f1_in_frame", in_frame, 0);
        check("f1_pyld_cnt", f_pyld, 0);
        check("f1_fas_err", f_fas, 0);
        send_frame(1, 0, 0, 0, 4164);
        check("f2_in_frame", in_frame, 1);
        check("f2_pyld_cnt", f_pyld, 4096);
        check("f2_err", f_err, 0);

        send_frame(1, 0, 0, 0, 4164);
        check("f3_pyld_cnt", f_pyld, 4096);
        check("f3_err", f_err, 0);
        check("f3_first_pyld", f_first, 8'h10);
        check("f3_first_sof", f_first_sof, 1);
        check("f3_sof_cnt", f_sof, 1);

        send_frame(1, 0, 1, 0, 4164);
        check("gap_pyld_cnt", f_pyld, 4096);
        check("gap_err", f_err, 0);
        check("gap_in_frame", in_frame, 1);

        for (int k = 0; k < 4; k++) begin
            send_frame(1, 1, 0, 0, 4164);
            check("bad_fas_err", f_fas, 1);
            check("bad_in_frame", in_frame, 1);
            check("bad_pyld_cnt", f_pyld, 4096);
        end
        send_frame(0, 1, 0, 0, 4164);
        check("thresh_fas_err", f_fas, 1);
        check("thresh_in_frame", in_frame, 0);
        check("thresh_pyld_cnt", f_pyld, 0);

        send_frame(0, 0, 0, 0, 4164);
        check("relock1_in_frame", in_frame, 0);
        check("relock1_fas_err", f_fas, 0);
        send_frame(1, 0, 0, 0, 4164);
        check("relock2_in_frame", in_frame, 1);
        check("relock2_pyld_cnt", f_pyld, 4096);
        check("relock2_err", f_err, 0);
`ifdef FAS_ERR_CNT_EN
        check("err_cnt_five", fas_err_cnt, 5);
`endif

        // Reset lands mid-row while a payload byte is being presented.
        send_frame(1, 0, 0, 0, 1041 + 500);
        check("pre_rst_valid", pyld_valid, 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        last_pd = 8'h00;
        tot_fas = 0;
        send_frame(0, 0, 0, 0, 4164);
        check("rst_r1_in_frame", in_frame, 0);
        check("rst_r1_pyld_cnt", f_pyld, 0);
        send_frame(1, 0, 0, 0, 4164);
        check("rst_r2_in_frame", in_frame, 1);
        check("rst_r2_pyld_cnt", f_pyld, 4096);
        check("rst_r2_err", f_err, 0);

        // False FAS inside payload while out of frame.
        do_reset();
        send_frame(0, 1, 0, 1, 4164);
        check("false_in_frame", in_frame, 0);
        check("false_pyld_cnt", f_pyld, 0);
        check("false_fas_err", f_fas, 0);
        send_frame(0, 0, 0, 0, 4164);
        check("presync_fas_err", f_fas, 1);
        check("presync_pyld_cnt", f_pyld, 0);
        check("presync_in_frame", in_frame, 0);
        check("presync_err", f_err, 0);
`ifdef FAS_ERR_CNT_EN
        check("err_cnt_after_rst", fas_err_cnt, 16'(tot_fas));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
